// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Sequences the shared multiplier and divider and the HI/LO registers for
//   MULT, DIV and DIVM. A one-cycle start request from the control FSM is
//   accepted only in IDLE. The sequencer then:
//     1. pulses mult_init or div_init,
//     2. waits out the fixed unit latency,
//     3. strobes hl_load with the matching hi/lo mux select,
//     4. pulses done.
//   A divide with a zero divisor never starts the divider. It finishes at once
//   with done and div_zero, and leaves HI/LO, div_op and hi_lo_sel untouched.
//
// Optional feature: define MULDIV_ABORT_EN to add the abort input. abort
//   cancels an operation while it is in INIT or RUN. Without the macro the
//   block behaves as if abort were tied low.
//
// Parameters
//   MULT_CYCLES  multiplier latency from init to valid result (1..2^CNT_W-1)
//   DIV_CYCLES   divider latency from init to valid result (1..2^CNT_W-1)
//   CNT_W        latency counter width
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   mult_start   in   request MULT, sampled in IDLE only
//   div_start    in   request DIV/DIVM, sampled in IDLE only
//   div_src_mdr  in   with div_start: 1 = dividend from MDR, 0 = from A
//   divisor      in   B register value, zero-checked at accept only
//   abort        in   (MULDIV_ABORT_EN only) cancel an op in INIT/RUN
//   mult_init    out  one-cycle multiplier start pulse
//   div_init     out  one-cycle divider start pulse
//   div_op       out  dividend mux select, latched at div accept
//   hi_lo_sel    out  HI/LO source: 0 = divider, 1 = multiplier; held after op
//   hl_load      out  one-cycle HI/LO load strobe
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle completion pulse
//   div_zero     out  one-cycle divide-by-zero flag, coincident with done
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic        div_src_mdr,
  input  logic [31:0] divisor,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  output logic        mult_init,
  output logic        div_init,
  output logic        div_op,
  output logic        hi_lo_sel,
  output logic        hl_load,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_LOAD,
    S_DONE,
    S_ZERO
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_hi_lo_sel;
  logic             w_hi_lo_sel_nxt;
  logic             r_div_op;
  logic             w_div_op_nxt;
  logic             w_abort;

`ifdef MULDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State register. hi_lo_sel and div_op live here too, so that every output
  // comes either from a flop or from a decode of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi_lo_sel <= 1'b0;
      r_div_op    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi_lo_sel <= w_hi_lo_sel_nxt;
      r_div_op    <= w_div_op_nxt;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hi_lo_sel_nxt = r_hi_lo_sel;
    w_div_op_nxt    = r_div_op;

    unique case (r_state)
      S_IDLE: begin
        // mult has priority. A div request that arrives in the same cycle is
        // dropped, not queued.
        if (mult_start) begin
          w_state_nxt     = S_INIT;
          w_hi_lo_sel_nxt = 1'b1;
        end else if (div_start) begin
          if (divisor != 32'd0) begin
            w_state_nxt     = S_INIT;
            w_hi_lo_sel_nxt = 1'b0;
            w_div_op_nxt    = div_src_mdr;
          end else begin
            // Trap here, before the divider is ever started.
            w_state_nxt = S_ZERO;
          end
        end
      end

      S_INIT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = r_hi_lo_sel ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end

      S_RUN: begin
        // The counter enters RUN holding N and leaves after the cycle in
        // which it reads 1, so RUN lasts exactly N cycles.
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ZERO:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state and flops only; no input reaches an
  // output combinationally.
  assign mult_init = (r_state == S_INIT) &&  r_hi_lo_sel;
  assign div_init  = (r_state == S_INIT) && !r_hi_lo_sel;
  assign hl_load   = (r_state == S_LOAD);
  assign done      = (r_state == S_DONE) || (r_state == S_ZERO);
  assign div_zero  = (r_state == S_ZERO);
  assign busy      = (r_state != S_IDLE);
  assign hi_lo_sel = r_hi_lo_sel;
  assign div_op    = r_div_op;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer. The bench also contains simple
//   behavioural multiplier and divider units plus HI/LO registers. These are
//   driven by the sequencer's init, load and mux-select outputs, so HI/LO end
//   up correct only when the sequencer routes each operation properly.
//
//   The driver decides, from its own accept timeline, which requests the
//   sequencer takes. For each accepted request it pushes one expected record.
//   A monitor runs every cycle: it compares the control outputs with the
//   record at the head of the queue, and checks HI/LO when that record
//   completes.
//
//   Cycle labels: cyc is the number of rising edges seen so far. An op
//   accepted at edge k shows its init pulse right after edge k, hl_load after
//   k+N+1 and done after k+N+2. A divide-by-zero shows done/div_zero after k.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int N_MULT = 32;
  localparam int N_DIV  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic        div_src_mdr = 1'b0;
  logic [31:0] divisor = 32'd0;
`ifdef MULDIV_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        mult_init, div_init, div_op, hi_lo_sel, hl_load, busy, done, div_zero;

  muldiv_sequencer #(
    .MULT_CYCLES(N_MULT),
    .DIV_CYCLES (N_DIV),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .div_src_mdr(div_src_mdr),
    .divisor    (divisor),
`ifdef MULDIV_ABORT_EN
    .abort      (abort),
`endif
    .mult_init  (mult_init),
    .div_init   (div_init),
    .div_op     (div_op),
    .hi_lo_sel  (hi_lo_sel),
    .hl_load    (hl_load),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // ---------------- arithmetic (signed, MIPS style) ----------------
  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    int    sa, sb;
    longint p;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    return p;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (sb == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // ---------------- environment: units and HI/LO ----------------
  logic [31:0] op_a = 32'd0, op_b = 32'd0, op_mdr = 32'd0;
  logic [31:0] mu_hi = 32'd0, mu_lo = 32'd0, du_r = 32'd0, du_q = 32'd0;
  logic [31:0] hi_reg = 32'd0, lo_reg = 32'd0;

  always @(posedge clk) begin
    if (mult_init) {mu_hi, mu_lo} <= smul(op_a, op_b);
    if (div_init)  {du_r, du_q}   <= sdiv(div_op ? op_mdr : op_a, op_b);
    if (hl_load) begin
      hi_reg <= hi_lo_sel ? mu_hi : du_r;
      lo_reg <= hi_lo_sel ? mu_lo : du_q;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          k;
    int          n;
    bit          zero;
    bit          is_mult;
    bit          src;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  bit   m_sel = 1'b0;
  bit   m_op  = 1'b0;

  // ---------------- driver-side reference state ----------------
  int          free_cyc = 0;    // first edge at which a start can be accepted
  bit          last_norm = 1'b0;
  int          last_k = 0, last_n = 0;
  logic [31:0] mh = 32'd0, ml = 32'd0, ph = 32'd0, pl = 32'd0;

  // Called just after a falling edge. The inputs are sampled on the next
  // rising edge; the task returns one falling edge later.
  task automatic drive_op(input bit ms, input bit ds, input bit src,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] mdr);
    int          r;
    exp_t        e;
    logic [63:0] res;
    r           = cyc + 1;
    mult_start  = ms;
    div_start   = ds;
    div_src_mdr = src;
    divisor     = b;
    if ((ms || ds) && r >= free_cyc) begin
      e.k       = r;
      e.is_mult = ms;
      e.src     = src;
      e.zero    = !ms && (b == 32'd0);
      op_a      = a;
      op_b      = b;
      op_mdr    = mdr;
      if (e.zero) begin
        e.n       = 0;
        e.hi      = mh;
        e.lo      = ml;
        free_cyc  = r + 2;
        last_norm = 1'b0;
      end else begin
        e.n       = ms ? N_MULT : N_DIV;
        res       = ms ? smul(a, b) : sdiv(src ? mdr : a, b);
        ph        = mh;
        pl        = ml;
        mh        = res[63:32];
        ml        = res[31:0];
        e.hi      = mh;
        e.lo      = ml;
        free_cyc  = r + e.n + 4;
        last_norm = 1'b1;
        last_k    = r;
        last_n    = e.n;
      end
      sb_q.push_back(e);
    end
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    // The divisor is only looked at on the accept edge, so junk here
    // (including zero) must not disturb the op that is already running.
    divisor    = $urandom_range(0, 1) ? 32'd0 : $urandom;
  endtask

  task automatic do_reset();
    int r;
    r     = cyc + 1;
    reset = 1'b1;
    if (last_norm && r <= last_k + last_n + 1) begin
      mh = ph;
      ml = pl;
    end
    last_norm = 1'b0;
    free_cyc  = r + 1;
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic do_abort();
    int r;
    r     = cyc + 1;
    abort = 1'b1;
    if (last_norm && r - 1 >= last_k && r - 1 <= last_k + last_n) begin
      mh        = ph;
      ml        = pl;
      last_norm = 1'b0;
      free_cyc  = r + 1;
    end
    @(negedge clk);
    abort = 1'b0;
  endtask
`endif

  task automatic wait_idle();
    while (cyc + 1 < free_cyc) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t       e;
    logic [5:0] want;
    int         fin;
    forever begin
      @(posedge clk);
      #1;
      want = '0;
      if (reset) begin
        sb_q.delete();
        m_sel = 1'b0;
        m_op  = 1'b0;
      end else begin
`ifdef MULDIV_ABORT_EN
        if (abort && sb_q.size() > 0) begin
          e = sb_q[0];
          if (!e.zero && cyc - 1 >= e.k && cyc - 1 <= e.k + e.n) void'(sb_q.pop_front());
        end
`endif
        if (sb_q.size() > 0) begin
          e = sb_q[0];
          if (e.zero) begin
            if (cyc == e.k) want = 6'b100011;
          end else begin
            if (cyc == e.k) begin
              m_sel = e.is_mult;
              if (!e.is_mult) m_op = e.src;
            end
            want[5] = (cyc >= e.k) && (cyc <= e.k + e.n + 2);
            want[4] = (cyc == e.k) &&  e.is_mult;
            want[3] = (cyc == e.k) && !e.is_mult;
            want[2] = (cyc == e.k + e.n + 1);
            want[1] = (cyc == e.k + e.n + 2);
          end
        end
      end
      // Bit order: {busy, mult_init, div_init, hl_load, done, div_zero}.
      check("ctl", 64'({busy, mult_init, div_init, hl_load, done, div_zero}), 64'(want));
      check("sel_op", 64'({hi_lo_sel, div_op}), 64'({m_sel, m_op}));
      if (!reset && sb_q.size() > 0) begin
        e   = sb_q[0];
        fin = e.zero ? e.k : e.k + e.n + 2;
        if (cyc == fin) begin
          check("hilo", {hi_reg, lo_reg}, {e.hi, e.lo});
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] a, b, mdr;
    bit          ms, ds, src;
    int          k0;

    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    free_cyc = cyc + 1;

    // T1: MULT 7 * -3 gives HI=FFFFFFFF, LO=FFFFFFEB.
    drive_op(1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'd0);
    wait_idle();

    // T2: DIVM 17 / 4 gives LO=4, HI=1; div_op latched to 1.
    drive_op(1'b0, 1'b1, 1'b1, 32'd100, 32'd4, 32'd17);
    wait_idle();

    // T2b: DIV from A, negative dividend: -17 / 5 gives LO=-3, HI=-2.
    drive_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFEF, 32'd5, 32'd9);
    wait_idle();

    // T3: divide by zero traps with no init and no load.
    drive_op(1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd3);
    wait_idle();

    // T4: simultaneous starts run mult only; a div_start while busy is ignored.
    k0 = cyc + 1;
    drive_op(1'b1, 1'b1, 1'b1, 32'd3, 32'd5, 32'd8);
    wait_until(k0 + 9);
    drive_op(1'b0, 1'b1, 1'b0, 32'd40, 32'd6, 32'd0);
    wait_idle();

    // T5: reset in mid-RUN cancels the op; a fresh MULT completes.
    k0 = cyc + 1;
    drive_op(1'b1, 1'b0, 1'b0, 32'd1000, 32'd1000, 32'd0);
    wait_until(k0 + 19);
    do_reset();
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'd0);
    wait_idle();

`ifdef MULDIV_ABORT_EN
    // T6: abort in RUN cancels the op; abort in LOAD is ignored.
    k0 = cyc + 1;
    drive_op(1'b0, 1'b1, 1'b0, 32'd77, 32'd7, 32'd0);
    wait_until(k0 + 4);
    do_abort();
    wait_idle();
    k0 = cyc + 1;
    drive_op(1'b0, 1'b1, 1'b0, 32'd99, 32'd10, 32'd0);
    wait_until(k0 + N_DIV + 1);
    do_abort();
    wait_idle();
`endif

    // Random traffic, with requests landing both while idle and while busy.
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
`ifdef MULDIV_ABORT_EN
      end else if ($urandom_range(0, 99) == 0) begin
        do_abort();
`endif
      end else if ($urandom_range(0, 3) == 0) begin
        ms  = 1'($urandom_range(0, 1));
        ds  = 1'($urandom_range(0, 1));
        src = 1'($urandom_range(0, 1));
        a   = $urandom;
        mdr = $urandom;
        case ($urandom_range(0, 3))
          0:       b = 32'd0;
          1:       b = $urandom_range(1, 9);
          2:       b = -$urandom_range(1, 9);
          default: b = $urandom;
        endcase
        if (b == 32'hFFFF_FFFF && (a == 32'h8000_0000 || mdr == 32'h8000_0000)) b = 32'd1;
        drive_op(ms, ds, src, a, b, mdr);
      end else begin
        @(negedge clk);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
